mdu_scheduler: RTL and testbench

- Sequencing controller for the EX-stage multiply/divide resource.
- Accepts start/op pulses from the EX-stage instruction, latches operands, and models the fixed MULT/DIV latency with a down-counter FSM.
- Commits results to the architectural HI/LO registers on completion, services MTHI/MTLO writes, and generates the decode-stage stall for any instruction that touches HI/LO while the unit is occupied.

---
 rtl/mdu_scheduler.sv | 115 +++++++++++
 tb/tb_mdu_scheduler.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_scheduler.sv
// Multiply/divide sequencer: latches a start, counts out the fixed MULT/DIV latency, then commits HI/LO.
// done pulses in the last busy cycle; stall holds D while a HI/LO user would collide with an op in flight.
module mdu_scheduler #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic        kill,
  input  logic        d_uses_md,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic {IDLE, RUN} state_e;

  localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_LAT - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       rhi_q, rhi_d, rlo_q, rlo_d;
  logic [31:0]       hi_q, hi_d, lo_q, lo_d;

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic               div_sgn;
  logic        [31:0] a_mag, b_mag, q_mag, r_mag, quot, rem;

  assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign prod_u = {32'd0, A} * {32'd0, B};

  // Divide on magnitudes so INT_MIN / -1 wraps to 0x80000000 with a zero remainder.
  assign div_sgn = ~op[0];
  assign a_mag   = (div_sgn & A[31]) ? (~A + 32'd1) : A;
  assign b_mag   = (div_sgn & B[31]) ? (~B + 32'd1) : B;
  assign q_mag   = (b_mag == 32'd0) ? 32'd0 : a_mag / b_mag;
  assign r_mag   = (b_mag == 32'd0) ? 32'd0 : a_mag % b_mag;
  assign quot    = (div_sgn & (A[31] ^ B[31])) ? (~q_mag + 32'd1) : q_mag;
  assign rem     = (div_sgn & A[31]) ? (~r_mag + 32'd1) : r_mag;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rhi_d   = rhi_q;
    rlo_d   = rlo_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (start && !kill) begin
          state_d = RUN;
          cnt_d   = op[1] ? DIV_LD : MULT_LD;
          case (op)
            2'd0:    {rhi_d, rlo_d} = prod_s;
            2'd1:    {rhi_d, rlo_d} = prod_u;
            default: begin
              // Divide by zero re-commits the current HI/LO, leaving them unchanged.
              if (B == 32'd0) {rhi_d, rlo_d} = {hi_q, lo_q};
              else            {rhi_d, rlo_d} = {rem, quot};
            end
          endcase
        end else if (!kill) begin
          if (mthi) hi_d = A;
          if (mtlo) lo_d = A;
        end
      end
      RUN: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          hi_d    = rhi_q;
          lo_d    = rlo_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rhi_q   <= '0;
      rlo_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rhi_q   <= rhi_d;
      rlo_q   <= rlo_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy  = (state_q == RUN);
  assign done  = (state_q == RUN) && (cnt_q == '0);
  assign stall = d_uses_md & (start | busy);
  assign HI    = hi_q;
  assign LO    = lo_q;

endmodule

// File: tb/tb_mdu_scheduler.sv
// Bench for mdu_scheduler: directed cases plus random traffic against a cycle-count reference model.
module tb_mdu_scheduler;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  logic        clk = 1'b0;
  logic        reset, start, mthi, mtlo, kill, d_uses_md;
  logic [1:0]  op;
  logic [31:0] A, B;
  logic        busy, stall, done;
  logic [31:0] HI, LO;

  int total = 0;
  int bad   = 0;

  mdu_scheduler #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .mthi(mthi), .mtlo(mtlo), .kill(kill), .d_uses_md(d_uses_md),
    .busy(busy), .stall(stall), .done(done), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    end
  endtask

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    bit          div0;
  } exp_t;

  exp_t sbq[$];

  // Reference arithmetic straight from the ISA definitions, using 64-bit integers.
  function automatic exp_t ref_calc(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    longint sa, sb, q, r;
    longint unsigned ua, ub, uq, ur;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    e.div0 = 1'b0;
    e.hi = '0;
    e.lo = '0;
    case (o)
      2'd0: begin p = sa * sb; e.hi = p[63:32]; e.lo = p[31:0]; end
      2'd1: begin p = ua * ub; e.hi = p[63:32]; e.lo = p[31:0]; end
      2'd2: begin
        if (b == 32'd0) e.div0 = 1'b1;
        else begin q = sa / sb; r = sa % sb; e.hi = r[31:0]; e.lo = q[31:0]; end
      end
      default: begin
        if (b == 32'd0) e.div0 = 1'b1;
        else begin uq = ua / ub; ur = ua % ub; e.hi = ur[31:0]; e.lo = uq[31:0]; end
      end
    endcase
    return e;
  endfunction

  // Model: remaining busy cycles plus architectural HI/LO.
  int          busy_left = 0;
  logic [31:0] m_hi = '0, m_lo = '0;
  exp_t        pend;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_left = 0;
      m_hi = '0;
      m_lo = '0;
      sbq.delete();
    end else if (busy_left > 0) begin
      if (start && !kill) begin
        total++;
        bad++;
        $display("FAIL start_in_run: got start=1 expected start=0 at %0t", $time);
      end
      busy_left--;
      if (busy_left == 0 && !pend.div0) begin
        m_hi = pend.hi;
        m_lo = pend.lo;
      end
    end else if (start && !kill) begin
      pend = ref_calc(op, A, B);
      busy_left = op[1] ? DIV_LAT : MULT_LAT;
      sbq.push_back(pend);
    end else if (!kill) begin
      if (mthi) m_hi = A;
      if (mtlo) m_lo = A;
    end
  end

  // Monitor: per-cycle control checks, and on done pops the scoreboard and checks the commit.
  bit          await_commit = 0;
  logic [31:0] exp_hi, exp_lo;

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      await_commit = 0;
    end else begin
      chk("busy", busy, busy_left > 0);
      chk("done", done, busy_left == 1);
      chk("stall", stall, d_uses_md & (start | (busy_left > 0)));
      chk("hi_arch", HI, m_hi);
      chk("lo_arch", LO, m_lo);
      if (await_commit) begin
        chk("hi_commit", HI, exp_hi);
        chk("lo_commit", LO, exp_lo);
        await_commit = 0;
      end
      if (done) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL done_unexpected: got done=1 expected no pending op at %0t", $time);
        end else begin
          e = sbq.pop_front();
          exp_hi = e.div0 ? m_hi : e.hi;
          exp_lo = e.div0 ? m_lo : e.lo;
          await_commit = 1;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic k);
    start = 1'b1; op = o; A = a; B = b; kill = k;
    cyc();
    start = 1'b0; kill = 1'b0;
  endtask

  task automatic run_out(output int n);
    n = 0;
    while ((busy || busy_left > 0) && n < 40) begin
      n++;
      cyc();
    end
    if (n >= 40) begin
      total++;
      bad++;
      $display("FAIL idle_timeout: got busy after %0d cycles expected idle", n);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    reset = 1'b0; start = 1'b0; op = '0; A = '0; B = '0;
    mthi = 1'b0; mtlo = 1'b0; kill = 1'b0; d_uses_md = 1'b0;
    cyc(); cyc();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hi", HI, 0);
    chk("rst_lo", LO, 0);
    reset = 1'b1;
    cyc();

    issue(2'd0, 32'hFFFF_FFFE, 32'd3, 1'b0);
    run_out(n);
    chk("mult_busy_len", n, 5);
    chk("mult_hi", HI, 32'hFFFF_FFFF);
    chk("mult_lo", LO, 32'hFFFF_FFFA);

    issue(2'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
    run_out(n);
    chk("multu_busy_len", n, 5);
    chk("multu_hi", HI, 32'h0000_0001);
    chk("multu_lo", LO, 32'hFFFF_FFFE);

    issue(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_out(n);
    chk("div_busy_len", n, 10);
    chk("div_hi", HI, 32'hFFFF_FFFF);
    chk("div_lo", LO, 32'hFFFF_FFFD);

    issue(2'd2, 32'hFFFF_FFF9, 32'd0, 1'b0);
    run_out(n);
    chk("div0_busy_len", n, 10);
    chk("div0_hi", HI, 32'hFFFF_FFFF);
    chk("div0_lo", LO, 32'hFFFF_FFFD);

    issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_out(n);
    chk("divovf_hi", HI, 32'h0000_0000);
    chk("divovf_lo", LO, 32'h8000_0000);

    mthi = 1'b1; A = 32'h1234_5678; cyc(); mthi = 1'b0;
    chk("mthi_hi", HI, 32'h1234_5678);
    mtlo = 1'b1; A = 32'h9ABC_DEF0; cyc(); mtlo = 1'b0;
    chk("mtlo_lo", LO, 32'h9ABC_DEF0);
    mthi = 1'b1; mtlo = 1'b1; kill = 1'b1; A = 32'hDEAD_BEEF; cyc();
    mthi = 1'b0; mtlo = 1'b0; kill = 1'b0;
    chk("mthi_kill_hi", HI, 32'h1234_5678);
    chk("mtlo_kill_lo", LO, 32'h9ABC_DEF0);

    issue(2'd0, 32'd2, 32'd3, 1'b0);
    cyc();
    mthi = 1'b1; A = 32'hCAFE_F00D; cyc(); mthi = 1'b0;
    run_out(n);
    chk("mthi_run_hi", HI, 32'h0000_0000);
    chk("mthi_run_lo", LO, 32'h0000_0006);

    issue(2'd3, 32'd100, 32'd7, 1'b1);
    chk("kill_busy", busy, 0);
    cyc();
    chk("kill_lo", LO, 32'h0000_0006);

    d_uses_md = 1'b1;
    start = 1'b1; op = 2'd1; A = 32'd9; B = 32'd9;
    #2 chk("stall_start", stall, 1);
    cyc(); start = 1'b0;
    run_out(n);
    chk("stall_after", stall, 0);
    d_uses_md = 1'b0;

    issue(2'd3, 32'd1000, 32'd7, 1'b0);
    cyc(); cyc();
    #2 reset = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_hi", HI, 0);
    chk("arst_lo", LO, 0);
    cyc();
    reset = 1'b1;
    cyc();
    issue(2'd3, 32'd1000, 32'd7, 1'b0);
    run_out(n);
    chk("post_rst_len", n, 10);
    chk("post_rst_hi", HI, 32'd6);
    chk("post_rst_lo", LO, 32'd142);

    for (int i = 0; i < 600; i++) begin
      d_uses_md = $urandom_range(0, 1);
      kill = ($urandom_range(0, 6) == 0);
      A = pick();
      B = pick();
      op = 2'($urandom_range(0, 3));
      if (busy_left == 0 && $urandom_range(0, 2) == 0) begin
        start = 1'b1;
      end else if ($urandom_range(0, 4) == 0) begin
        if ($urandom_range(0, 1) == 0) mthi = 1'b1;
        else mtlo = 1'b1;
      end
      cyc();
      start = 1'b0; mthi = 1'b0; mtlo = 1'b0; kill = 1'b0;
    end
    run_out(n);
    cyc(); cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "watchdog");
  end

endmodule
